cache_port_arb: RTL and testbench
=================================

CACHE_PORT_ARB -- requirements
Module: cache_port_arb

Interface
REQ-001 Parameter MAX_WAIT, default 4, starvation threshold in cycles; legal range 1..15.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 i_req  input  1  instruction-side request; held high until i_ack.
REQ-005 i_force  input  1  instruction-side must-issue qualifier; meaningful only with i_req.
REQ-006 d_req  input  1  data-side request; held high until d_ack.
REQ-007 d_force  input  1  data-side must-issue qualifier; meaningful only with d_req.
REQ-008 cache_busy_n  input  1  cache ready, active-low busy.
REQ-009 cache_enable  output  1  one-cycle transaction issue strobe to cache.
REQ-010 cache_sel  output  1  owner of the cache port: 0 = I, 1 = D; valid in ISSUE and WAIT.
REQ-011 i_ack, d_ack  output  1 each  one-cycle completion pulse to the owning requester.
REQ-012 i_stall, d_stall  output  1 each  combinational: X_stall = X_req & ~X_ack.

Function
REQ-013 FSM states: IDLE, ISSUE, WAIT.
REQ-014 cache_enable SHALL be 1 exactly when state = ISSUE.
REQ-015 IDLE -> ISSUE when a winner exists and either cache_busy_n = 1 or the winner's force = 1; otherwise the FSM stays in IDLE.
REQ-016 ISSUE -> WAIT unconditionally after one cycle.
REQ-017 In WAIT with cache_busy_n = 1:
- assert ack for cache_sel, combinationally, that cycle;
- if the other port has req = 1, go to ISSUE with it as winner;
- else go to IDLE.
REQ-018 WAIT with cache_busy_n = 0 SHALL remain in WAIT, with no acknowledge.
REQ-019 Winner priority, highest first:
- d_force
- i_force
- starved port; if both ports are starved, the port not last served
- round-robin: the requesting port not last served
- a sole requester wins.
REQ-020 The port being acked in the current cycle SHALL be excluded from arbitration in that cycle.
REQ-021 last_served register (1 bit) SHALL load the winner on entry to ISSUE.
REQ-022 Per-port 4-bit wait counter:
- increments each cycle req = 1 and the port is not the owner in ISSUE/WAIT;
- saturates at MAX_WAIT;
- clears on its ack or when req = 0.
- The port is starved when counter = MAX_WAIT.
REQ-023 cache_sel SHALL be registered and stable from ISSUE through the ack cycle.
REQ-024 Minimum latency: req at cycle N (IDLE, cache_busy_n = 1) -> cache_enable at N+1 -> ack at N+2 if cache_busy_n = 1 at N+2.
REQ-025 If the owner drops req mid-transaction, the transaction SHALL complete and ack SHALL still pulse.
REQ-026 Simultaneous i_force and d_force: D wins; I is issued next via REQ-017.

Reset
REQ-027 rst = 1 at an edge SHALL force state = IDLE, last_served = 1 (I wins the first tie), wait counters = 0, cache_sel = 0.
REQ-028 Reset SHALL take priority over all transitions.
REQ-029 An in-flight transaction is abandoned on reset, with no ack.
REQ-030 cache_enable, i_ack and d_ack SHALL be 0 in the cycle after reset is sampled.

Structure
REQ-031 FSM state encoding, port index constants (PORT_I = 0, PORT_D = 1) and the counter width SHALL live in a shared package aexm_cache_pkg.
REQ-032 The per-port wait counter SHALL be one sub-module, arb_wait_ctr, instantiated twice.
REQ-033 No other hierarchy.

Verification
REQ-034 Reset, then i_req = 1 and cache_busy_n = 1 from cycle 0 -> cache_enable = 1 and cache_sel = 0 at cycle 1; i_ack = 1 at cycle 2.
REQ-035 i_req and d_req rise together for 3 back-to-back rounds, cache_busy_n = 1 -> issue order I, D, I, D, I, D; no IDLE cycle between grants.
REQ-036 d_force = 1 while cache_busy_n = 0 in IDLE -> cache_enable = 1 and cache_sel = 1 next cycle; d_ack only after cache_busy_n returns to 1.
REQ-037 MAX_WAIT = 2: I repeatedly re-requests with i_force = 1 while D is waiting -> D is issued at the latest when forces cease, never starved indefinitely. With no forces, D's wait counter reads 2 and D wins over the round-robin choice.
REQ-038 rst = 1 asserted in WAIT with cache_sel = 1 -> next cycle state = IDLE, d_ack = 0, cache_enable = 0; a fresh d_req is reissued normally afterwards.

Source files
------------

// File: rtl/aexm_cache_pkg.sv
// rtl/aexm_cache_pkg.sv - shared FSM encoding, port indices and counter width for the cache port arbiter
package aexm_cache_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2
   } arb_state_e;

   localparam logic PORT_I = 1'b0;
   localparam logic PORT_D = 1'b1;
   localparam int   CTR_W  = 4;

endpackage

// File: rtl/arb_wait_ctr.sv
// rtl/arb_wait_ctr.sv - per-port saturating wait counter; flags starvation at MAX_WAIT
module arb_wait_ctr
   import aexm_cache_pkg::*;
#(
   parameter int MAX_WAIT = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic req,
   input  logic owner,
   input  logic ack,
   output logic starved
);

   localparam logic [CTR_W-1:0] MAX_CNT = CTR_W'(MAX_WAIT);

   logic [CTR_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (ack || !req) begin
         cnt_d = '0;
      end else if (!owner && cnt_q != MAX_CNT) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign starved = (cnt_q == MAX_CNT);

endmodule

// File: rtl/cache_port_arb.sv
// rtl/cache_port_arb.sv - two-port (instruction/data) arbiter for a single cache port
module cache_port_arb
   import aexm_cache_pkg::*;
#(
   parameter int MAX_WAIT = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic i_req,
   input  logic i_force,
   input  logic d_req,
   input  logic d_force,
   input  logic cache_busy_n,
   output logic cache_enable,
   output logic cache_sel,
   output logic i_ack,
   output logic d_ack,
   output logic i_stall,
   output logic d_stall
);

   arb_state_e state_q, state_d;
   logic       sel_q, sel_d;
   logic       last_q, last_d;
   logic       i_starved, d_starved;
   logic       i_cand, d_cand;
   logic       win_valid, win_port, win_force;
   logic       done;

   assign done         = (state_q == ST_WAIT) && cache_busy_n;
   assign i_ack        = done && (sel_q == PORT_I);
   assign d_ack        = done && (sel_q == PORT_D);
   assign i_stall      = i_req & ~i_ack;
   assign d_stall      = d_req & ~d_ack;
   assign cache_enable = (state_q == ST_ISSUE);
   assign cache_sel    = sel_q;

   // A port being acknowledged this cycle cannot also win the next slot
   assign i_cand = i_req & ~i_ack;
   assign d_cand = d_req & ~d_ack;

   arb_wait_ctr #(.MAX_WAIT(MAX_WAIT)) u_i_ctr (
      .clk     (clk),
      .rst     (rst),
      .req     (i_req),
      .owner   ((state_q != ST_IDLE) && (sel_q == PORT_I)),
      .ack     (i_ack),
      .starved (i_starved)
   );

   arb_wait_ctr #(.MAX_WAIT(MAX_WAIT)) u_d_ctr (
      .clk     (clk),
      .rst     (rst),
      .req     (d_req),
      .owner   ((state_q != ST_IDLE) && (sel_q == PORT_D)),
      .ack     (d_ack),
      .starved (d_starved)
   );

   always_comb begin
      win_valid = i_cand | d_cand;
      win_port  = PORT_I;
      if (d_cand && d_force) begin
         win_port = PORT_D;
      end else if (i_cand && i_force) begin
         win_port = PORT_I;
      end else if (i_cand && i_starved && d_cand && d_starved) begin
         win_port = ~last_q;
      end else if (i_cand && i_starved) begin
         win_port = PORT_I;
      end else if (d_cand && d_starved) begin
         win_port = PORT_D;
      end else if (i_cand && d_cand) begin
         win_port = ~last_q;
      end else if (d_cand) begin
         win_port = PORT_D;
      end
      win_force = (win_port == PORT_D) ? d_force : i_force;
   end

   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      last_d  = last_q;
      unique case (state_q)
         ST_IDLE: begin
            if (win_valid && (cache_busy_n || win_force)) begin
               state_d = ST_ISSUE;
               sel_d   = win_port;
               last_d  = win_port;
            end
         end
         ST_ISSUE: state_d = ST_WAIT;
         ST_WAIT: begin
            if (cache_busy_n) begin
               if (win_valid) begin
                  state_d = ST_ISSUE;
                  sel_d   = win_port;
                  last_d  = win_port;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         sel_q   <= PORT_I;
         last_q  <= PORT_D;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         last_q  <= last_d;
      end
   end

endmodule

// File: tb/tb_cache_port_arb.sv
// tb/tb_cache_port_arb.sv - directed bench for cache_port_arb with an issue-order scoreboard
module tb_cache_port_arb;
   import aexm_cache_pkg::*;

   logic clk;
   logic rst;
   logic i_req, i_force, d_req, d_force, cache_busy_n;
   logic cache_enable, cache_sel, i_ack, d_ack, i_stall, d_stall;

   int   n_cmp = 0;
   int   n_err = 0;
   logic exp_q[$];

   cache_port_arb #(.MAX_WAIT(2)) dut (
      .clk          (clk),
      .rst          (rst),
      .i_req        (i_req),
      .i_force      (i_force),
      .d_req        (d_req),
      .d_force      (d_force),
      .cache_busy_n (cache_busy_n),
      .cache_enable (cache_enable),
      .cache_sel    (cache_sel),
      .i_ack        (i_ack),
      .d_ack        (d_ack),
      .i_stall      (i_stall),
      .d_stall      (d_stall)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Every issue strobe must match the next port the bench expects to be granted
   always @(negedge clk) begin
      if (cache_enable === 1'b1) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_issue", 32'(cache_sel), 32'hdead);
         end else begin
            chk("issue_sel", 32'(cache_sel), 32'(exp_q.pop_front()));
         end
      end
   end

   task automatic do_reset();
      rst = 1'b1;
      i_req = 1'b0; i_force = 1'b0; d_req = 1'b0; d_force = 1'b0;
      cache_busy_n = 1'b1;
      cyc();
      cyc();
      chk("rst_enable", 32'(cache_enable), 0);
      chk("rst_sel", 32'(cache_sel), 0);
      chk("rst_iack", 32'(i_ack), 0);
      chk("rst_dack", 32'(d_ack), 0);
      chk("rst_state", 32'(dut.state_q), 32'(ST_IDLE));
      rst = 1'b0;
   endtask

   initial begin
      do_reset();

      // Minimum latency, instruction side
      i_req = 1'b1; exp_q.push_back(PORT_I);
      cyc();
      chk("lat_enable", 32'(cache_enable), 1);
      chk("lat_sel", 32'(cache_sel), 0);
      cyc();
      chk("lat_iack", 32'(i_ack), 1);
      chk("lat_istall", 32'(i_stall), 0);
      i_req = 1'b0;
      cyc();
      chk("lat_idle", 32'(cache_enable), 0);

      // Back-to-back alternation with both ports requesting
      do_reset();
      i_req = 1'b1; d_req = 1'b1;
      repeat (3) begin exp_q.push_back(PORT_I); exp_q.push_back(PORT_D); end
      for (int k = 1; k <= 12; k++) begin
         cyc();
         chk("rr_enable", 32'(cache_enable), 32'(k % 2 == 1));
         chk("rr_iack", 32'(i_ack), 32'(k % 4 == 2));
         chk("rr_dack", 32'(d_ack), 32'(k % 4 == 0));
         if (k == 10) i_req = 1'b0;
         if (k == 12) d_req = 1'b0;
      end
      cyc();
      chk("rr_idle", 32'(cache_enable), 0);

      // Forced data issue while the cache reports busy
      cache_busy_n = 1'b0; d_req = 1'b1; d_force = 1'b1; exp_q.push_back(PORT_D);
      cyc();
      chk("frc_enable", 32'(cache_enable), 1);
      chk("frc_sel", 32'(cache_sel), 1);
      cyc();
      chk("frc_noack1", 32'(d_ack), 0);
      chk("frc_dstall", 32'(d_stall), 1);
      cyc();
      chk("frc_noack2", 32'(d_ack), 0);
      cache_busy_n = 1'b1;
      #1;
      chk("frc_dack", 32'(d_ack), 1);
      cyc();
      d_req = 1'b0; d_force = 1'b0;
      cyc();
      chk("frc_idle", 32'(cache_enable), 0);

      // Instruction forcing cannot lock data out
      i_req = 1'b1; i_force = 1'b1; d_req = 1'b1;
      exp_q.push_back(PORT_I); exp_q.push_back(PORT_D); exp_q.push_back(PORT_I);
      cyc();
      cyc();
      chk("ifrc_iack", 32'(i_ack), 1);
      cyc();
      chk("ifrc_d_issue", 32'(cache_sel), 1);
      cyc();
      chk("ifrc_dack", 32'(d_ack), 1);
      d_req = 1'b0;
      cyc();
      cyc();
      chk("ifrc_iack2", 32'(i_ack), 1);
      i_req = 1'b0; i_force = 1'b0;
      cyc();
      chk("ifrc_idle", 32'(cache_enable), 0);

      // Serve D once so round-robin would next prefer I
      d_req = 1'b1; exp_q.push_back(PORT_D);
      cyc();
      cyc();
      chk("d_only_ack", 32'(d_ack), 1);
      d_req = 1'b0;
      cyc();

      // Starved D beats the round-robin choice
      d_req = 1'b1; cache_busy_n = 1'b0;
      cyc();
      cyc();
      chk("stv_count", 32'(dut.u_d_ctr.cnt_q), 2);
      chk("stv_held", 32'(cache_enable), 0);
      i_req = 1'b1; cache_busy_n = 1'b1;
      exp_q.push_back(PORT_D); exp_q.push_back(PORT_I);
      cyc();
      chk("stv_sel", 32'(cache_sel), 1);
      cyc();
      chk("stv_dack", 32'(d_ack), 1);
      d_req = 1'b0;
      cyc();
      cyc();
      chk("stv_iack", 32'(i_ack), 1);
      i_req = 1'b0;
      cyc();

      // Reset during a data transaction abandons it
      d_req = 1'b1; exp_q.push_back(PORT_D);
      cyc();
      cache_busy_n = 1'b0;
      cyc();
      chk("rw_sel", 32'(cache_sel), 1);
      chk("rw_noack", 32'(d_ack), 0);
      rst = 1'b1;
      cyc();
      chk("rw_state", 32'(dut.state_q), 32'(ST_IDLE));
      chk("rw_enable", 32'(cache_enable), 0);
      chk("rw_dack", 32'(d_ack), 0);
      chk("rw_selrst", 32'(cache_sel), 0);
      rst = 1'b0; cache_busy_n = 1'b1; exp_q.push_back(PORT_D);
      cyc();
      chk("rw_reissue", 32'(cache_enable), 1);
      cyc();
      chk("rw_dack2", 32'(d_ack), 1);
      d_req = 1'b0;
      cyc();
      chk("rw_idle", 32'(cache_enable), 0);

      chk("sb_drained", 32'(exp_q.size()), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
